// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_t   : sequencer FSM states (RUN, MEM_WAIT, HALT)
//   NOP_INSTR : encoding loaded into IF/ID when it is flushed (addi x0,x0,0)
//   REG_X0    : architectural zero register index, never a real hazard source
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_detect
// Purely combinational load-use hazard detector. Flags when the instruction in
// ID reads a register that the load currently in EX will write.
// Ports:
//   id_rs1, id_rs2           in  source register indices of the ID instruction
//   id_uses_rs1, id_uses_rs2 in  ID instruction actually reads rs1 / rs2
//   ex_rd                    in  destination index of the EX instruction
//   ex_mem_read              in  EX instruction is a load
//   load_use                 out one-bubble stall required
// -----------------------------------------------------------------------------
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // Writes to x0 are discarded, so a load targeting x0 never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule : pipe_hazard_detect

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Detects load-use
// hazards, applies EX-resolved redirects and freezes the whole pipeline while
// data memory is busy, with a sticky fault if memory never answers.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add three 32-bit wrapping
// performance counters (perf_stall_cnt, perf_flush_cnt, perf_wait_cnt).
//
// Parameters:
//   MEM_TIMEOUT : max consecutive wait cycles before fault (>= 1)
//   CNT_W       : wait counter width, 2**CNT_W > MEM_TIMEOUT
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            ID source indices
//   id_uses_rs1/id_uses_rs2  ID source-read enables
//   ex_rd, ex_mem_read       EX destination and load flag
//   ex_redirect              EX resolved a taken branch/jump
//   mem_req, mem_ready       MEM stage access pending / completing
//   pc_stall, if_id_stall    hold PC / IF/ID
//   if_id_flush              load NOP into IF/ID
//   id_ex_flush              bubble into ID/EX
//   ex_mem_flush             bubble into EX/MEM
//   freeze                   hold every pipeline register and the PC
//   mem_err                  sticky memory-timeout fault
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       freeze,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_wait_cnt,
`endif
    output logic       mem_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             mem_err_next;
    logic             load_use;
    logic             apply_rules;

    pipe_hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // EX/MEM never needs a bubble outside reset, and reset already forces every
    // control output low while the register itself is cleared by rst.
    assign ex_mem_flush = 1'b0;

    // NOTE: every signal written below gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_err_next  = mem_err;
        apply_rules   = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        freeze        = 1'b0;

        if (rst) begin
            // Outputs stay at their zero defaults for the reset cycle.
            state_next    = RUN;
            wait_cnt_next = '0;
            mem_err_next  = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        freeze        = 1'b1;
                        state_next    = MEM_WAIT;
                        wait_cnt_next = CNT_W'(1);
                    end else begin
                        apply_rules = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        // Memory completes this edge, so the pipeline moves and
                        // the ordinary redirect/hazard rules take effect now.
                        apply_rules   = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else if (wait_cnt == TIMEOUT_VAL) begin
                        freeze       = 1'b1;
                        state_next   = HALT;
                        mem_err_next = 1'b1;
                    end else begin
                        freeze        = 1'b1;
                        wait_cnt_next = wait_cnt + CNT_W'(1);
                    end
                end
                HALT: begin
                    freeze       = 1'b1;
                    mem_err_next = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase

            if (apply_rules) begin
                if (ex_redirect) begin
                    // The ID instruction is squashed, so any hazard it carries
                    // is irrelevant; the PC must load the target.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID one cycle and insert a single bubble.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        state    <= state_next;
        wait_cnt <= wait_cnt_next;
        mem_err  <= mem_err_next;
    end

`ifdef PIPE_CTRL_PERF_EN
    // Each counter advances on the same edge its qualifying output is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (pc_stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (if_id_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (freeze)      perf_wait_cnt  <= perf_wait_cnt  + 32'd1;
        end
    end
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl with MEM_TIMEOUT=4. Inputs change just after the
// falling edge; combinational outputs are sampled 1 time unit later, well away
// from the rising edge that updates state.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic       mem_req, mem_ready;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic       ex_mem_flush, freeze, mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .freeze       (freeze),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_wait_cnt  (perf_wait_cnt),
`endif
        .mem_err      (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Checks the six control outputs: pc_stall, if_id_stall, if_id_flush,
    // id_ex_flush, freeze; ex_mem_flush is always expected low.
    task automatic check_outs(input string tag, input logic e_pcs, input logic e_ifs,
                              input logic e_iff, input logic e_idf, input logic e_frz);
        check({tag, ".pc_stall"},     {31'd0, pc_stall},     {31'd0, e_pcs});
        check({tag, ".if_id_stall"},  {31'd0, if_id_stall},  {31'd0, e_ifs});
        check({tag, ".if_id_flush"},  {31'd0, if_id_flush},  {31'd0, e_iff});
        check({tag, ".id_ex_flush"},  {31'd0, id_ex_flush},  {31'd0, e_idf});
        check({tag, ".freeze"},       {31'd0, freeze},       {31'd0, e_frz});
        check({tag, ".ex_mem_flush"}, {31'd0, ex_mem_flush}, 32'd0);
    endtask

    // Advance to the next falling edge and apply a new input vector.
    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic redir, input logic req, input logic rdy);
        @(negedge clk);
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_redirect = redir; mem_req = req; mem_ready = rdy;
        #1;
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = '0; ex_mem_read = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;

        // Reset: outputs forced low even with a hazard and a memory stall present.
        step(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0);
        check_outs("rst_hazard", 0, 0, 0, 0, 0);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        check_outs("rst_idle", 0, 0, 0, 0, 0);

        // Load-use on rs1: exactly one stall cycle.
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        check_outs("lu_rs1", 1, 1, 0, 1, 0);
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0);
        check_outs("lu_after", 0, 0, 0, 0, 0);

        // Load-use on rs2; then same indices with rs2 unused.
        step(0, 5'd1, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0);
        check_outs("lu_rs2", 1, 1, 0, 1, 0);
        step(0, 5'd1, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0);
        check_outs("lu_rs2_unused", 0, 0, 0, 0, 0);
        step(0, 5'd3, 5'd4, 1, 1, 5'd9, 1, 0, 0, 0);
        check_outs("lu_no_match", 0, 0, 0, 0, 0);

        // Loads into x0 never stall.
        step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
        check_outs("x0_exempt", 0, 0, 0, 0, 0);

        // Redirect wins over a simultaneous load-use; PC must not stall.
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
        check_outs("redir_lu", 0, 0, 1, 1, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
        check_outs("redir_only", 0, 0, 1, 1, 0);

        // Memory wait: three frozen cycles (freeze beats the hazard), release on ready.
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0);
        check_outs("wait_c1", 0, 0, 0, 0, 1);
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0);
        check_outs("wait_c2", 0, 0, 0, 0, 1);
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0);
        check_outs("wait_c3", 0, 0, 0, 0, 1);
        // Release cycle: hazard rules apply again.
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 1);
        check_outs("wait_release", 1, 1, 0, 1, 0);
        // Back in RUN: no request and not ready must not freeze.
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        check_outs("wait_back_run", 0, 0, 0, 0, 0);
        check("wait_no_err", {31'd0, mem_err}, 32'd0);

        // Timeout with MEM_TIMEOUT=4: entry edge plus four wait edges -> HALT.
        for (int i = 1; i <= 5; i++) begin
            step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
            check_outs($sformatf("to_c%0d", i), 0, 0, 0, 0, 1);
            check($sformatf("to_err_c%0d", i), {31'd0, mem_err}, 32'd0);
        end
        // After the fifth edge: HALT, sticky even with memory ready and a redirect.
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
        check("halt_err", {31'd0, mem_err}, 32'd1);
        check_outs("halt", 0, 0, 0, 0, 1);
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1);
        check("halt_err2", {31'd0, mem_err}, 32'd1);
        check_outs("halt2", 0, 0, 0, 0, 1);

        // Reset out of HALT.
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        check_outs("halt_rst", 0, 0, 0, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        check("halt_rst_err", {31'd0, mem_err}, 32'd0);
        check_outs("halt_rst_run", 0, 0, 0, 0, 0);

        // Load-use check after HALT recovery confirms normal RUN behaviour.
        step(0, 5'd2, 5'd0, 1, 0, 5'd2, 1, 0, 0, 0);
        check_outs("post_halt_lu", 1, 1, 0, 1, 0);

        // Reset mid-wait.
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        check_outs("mw_enter", 0, 0, 0, 0, 1);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        check_outs("mw_rst", 0, 0, 0, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        check_outs("mw_run", 0, 0, 0, 0, 0);
        check("mw_err", {31'd0, mem_err}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check("mw_perf_stall", perf_stall_cnt, 32'd0);
        check("mw_perf_flush", perf_flush_cnt, 32'd0);
        check("mw_perf_wait",  perf_wait_cnt,  32'd0);
        // One stall, one flush, one freeze cycle, then sample the counters.
        step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
        check("perf_stall", perf_stall_cnt, 32'd1);
        check("perf_flush", perf_flush_cnt, 32'd1);
        check("perf_wait",  perf_wait_cnt,  32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipe_ctrl
